multicycle_control: RTL

- Parametrised multi-cycle successor to the single-cycle instruction decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states. Stalls on a req/ready memory handshake and counts retired instructions.
- Sits between the instruction register, the datapath muxes and the shared instruction/data memory port.

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC|ADDR/MEM/WB|BRANCH|JUMP, 3-5 cycles per instruction when memory is ready,
// stalls in FETCH/MEM until mem_ready, counts retirements; define ILLEGAL_TRAP_EN to trap illegal opcodes in TRAP.
module multicycle_control #(
  parameter int XLEN = 32,
  parameter int OPW  = 6,
  parameter int ALUW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ins,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_write,
  output logic            memWrite,
  output logic            memToReg,
  output logic            regDst,
  output logic            regWriteEnable,
  output logic            ALUSrc,
  output logic [ALUW-1:0] ALUControl,
  output logic            branchEnable,
  output logic            jump,
  output logic            busy,
`ifdef ILLEGAL_TRAP_EN
  output logic            illegal_op,
`endif
  output logic [CNTW-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM, S_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_ALU, C_ALUI, C_LW, C_SW, C_BLEU, C_JR, C_JAL, C_ILL
  } cls_t;

  localparam logic [OPW-1:0] OP_ANDR = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_JR   = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b000011);
  localparam logic [OPW-1:0] OP_NORR = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_NORI = OPW'(6'b001110);
  localparam logic [OPW-1:0] OP_NOTR = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BLEU = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_ROLV = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_RORV = OPW'(6'b000010);

  state_t          state, next_state;
  cls_t            cls_q, dec_cls;
  logic [ALUW-1:0] alu_q;
  logic            retire;
  logic [OPW-1:0]  opcode;
  logic            unused_ins;

  assign opcode     = ins[XLEN-1 -: OPW];
  assign unused_ins = ^ins;

  always_comb begin
    case (opcode)
      OP_ANDR, OP_NORR, OP_NOTR, OP_ROLV, OP_RORV: dec_cls = C_ALU;
      OP_NORI: dec_cls = C_ALUI;
      OP_LW:   dec_cls = C_LW;
      OP_SW:   dec_cls = C_SW;
      OP_BLEU: dec_cls = C_BLEU;
      OP_JR:   dec_cls = C_JR;
      OP_JAL:  dec_cls = C_JAL;
      default: dec_cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      cls_q         <= C_NONE;
      alu_q         <= '0;
      retired_count <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        cls_q <= dec_cls;
        alu_q <= ins[XLEN-1 -: ALUW];
      end
      if (retire) retired_count <= retired_count + 1'b1;
    end
  end

  always_comb begin
    next_state     = state;
    retire         = 1'b0;
    mem_req        = 1'b0;
    iord           = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    memWrite       = 1'b0;
    memToReg       = 1'b0;
    regDst         = 1'b0;
    regWriteEnable = 1'b0;
    ALUSrc         = 1'b0;
    ALUControl     = '0;
    branchEnable   = 1'b0;
    jump           = 1'b0;
    busy           = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    illegal_op     = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        busy    = 1'b0;
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      // Only the next-state choice depends on ins; datapath controls stay idle here.
      S_DECODE: begin
        case (dec_cls)
          C_ALU, C_ALUI: next_state = S_EXEC;
          C_LW, C_SW:    next_state = S_ADDR;
          C_BLEU:        next_state = S_BRANCH;
          C_JR, C_JAL:   next_state = S_JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            next_state = S_TRAP;
`else
            next_state = S_FETCH;
            retire     = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC: begin
        ALUControl = alu_q;
        ALUSrc     = (cls_q == C_ALUI);
        next_state = S_WB;
      end
      S_ADDR: begin
        ALUSrc     = 1'b1;
        ALUControl = alu_q;
        next_state = S_MEM;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memWrite = (cls_q == C_SW);
        if (mem_ready) begin
          if (cls_q == C_SW) begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        regWriteEnable = 1'b1;
        regDst         = (cls_q == C_ALU);
        memToReg       = (cls_q == C_LW);
        next_state     = S_FETCH;
        retire         = 1'b1;
      end
      S_BRANCH: begin
        branchEnable = 1'b1;
        ALUControl   = alu_q;
        next_state   = S_FETCH;
        retire       = 1'b1;
      end
      S_JUMP: begin
        jump           = 1'b1;
        pc_write       = 1'b1;
        regWriteEnable = (cls_q == C_JAL);
        next_state     = S_FETCH;
        retire         = 1'b1;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
`endif
      end
      default: next_state = S_FETCH;
    endcase
    // Outputs must drop as soon as reset asserts, not at the next edge.
    if (!rst_n) begin
      mem_req        = 1'b0;
      iord           = 1'b0;
      ir_write       = 1'b0;
      pc_write       = 1'b0;
      memWrite       = 1'b0;
      memToReg       = 1'b0;
      regDst         = 1'b0;
      regWriteEnable = 1'b0;
      ALUSrc         = 1'b0;
      ALUControl     = '0;
      branchEnable   = 1'b0;
      jump           = 1'b0;
      busy           = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_op     = 1'b0;
`endif
    end
  end

endmodule
